// File: rtl/cpu_exc_pkg.sv
// Shared exception types and constants for the MEM-stage exception commit path.
package cpu_exc_pkg;

    // Decoded MEM-stage exception flags, MSB first.
    typedef struct packed {
        logic refetch;
        logic tlb_refill_if;
        logic tlb_invalid_if;
        logic cpu;
        logic ri;
        logic syscall;
        logic brk;
        logic eret;
        logic trap;
        logic ov;
        logic ades;
        logic adel;
    } ExceptinPipeType;

    localparam int unsigned EXC_FLAGS_W = $bits(ExceptinPipeType);
    localparam int unsigned EXC_CODE_W  = 5;
    localparam int unsigned ENTRY_SEL_W = 3;
    localparam int unsigned TLB_EXC_W   = 3;

    localparam logic [EXC_CODE_W-1:0] EX_None              = 5'd0;
    localparam logic [EXC_CODE_W-1:0] EX_Interrupt         = 5'd1;
    localparam logic [EXC_CODE_W-1:0] EX_AdELIF            = 5'd2;
    localparam logic [EXC_CODE_W-1:0] EX_TLBRefillIF       = 5'd3;
    localparam logic [EXC_CODE_W-1:0] EX_TLBInvalidIF      = 5'd4;
    localparam logic [EXC_CODE_W-1:0] EX_CpU               = 5'd5;
    localparam logic [EXC_CODE_W-1:0] EX_RI                = 5'd6;
    localparam logic [EXC_CODE_W-1:0] EX_Syscall           = 5'd7;
    localparam logic [EXC_CODE_W-1:0] EX_Break             = 5'd8;
    localparam logic [EXC_CODE_W-1:0] EX_Eret              = 5'd9;
    localparam logic [EXC_CODE_W-1:0] EX_Trap              = 5'd10;
    localparam logic [EXC_CODE_W-1:0] EX_Ov                = 5'd11;
    localparam logic [EXC_CODE_W-1:0] EX_AdES              = 5'd12;
    localparam logic [EXC_CODE_W-1:0] EX_AdEL              = 5'd13;
    localparam logic [EXC_CODE_W-1:0] EX_RdTLBRefillinMEM  = 5'd14;
    localparam logic [EXC_CODE_W-1:0] EX_WrTLBRefillinMEM  = 5'd15;
    localparam logic [EXC_CODE_W-1:0] EX_RdTLBInvalidinMEM = 5'd16;
    localparam logic [EXC_CODE_W-1:0] EX_WrTLBInvalidinMEM = 5'd17;
    localparam logic [EXC_CODE_W-1:0] EX_Mod               = 5'd18;
    localparam logic [EXC_CODE_W-1:0] EX_Refetch           = 5'd19;

    localparam logic [ENTRY_SEL_W-1:0] IsNone      = 3'd0;
    localparam logic [ENTRY_SEL_W-1:0] IsException = 3'd1;
    localparam logic [ENTRY_SEL_W-1:0] IsEret      = 3'd2;
    localparam logic [ENTRY_SEL_W-1:0] IsRefetch   = 3'd3;

    localparam logic [TLB_EXC_W-1:0] MEM_NoExc          = 3'd0;
    localparam logic [TLB_EXC_W-1:0] MEM_RdTLBRefill    = 3'd1;
    localparam logic [TLB_EXC_W-1:0] MEM_RdTLBInvalid   = 3'd2;
    localparam logic [TLB_EXC_W-1:0] MEM_WrTLBRefill    = 3'd3;
    localparam logic [TLB_EXC_W-1:0] MEM_WrTLBInvalid   = 3'd4;
    localparam logic [TLB_EXC_W-1:0] MEM_TLBModified    = 3'd5;

    localparam logic [31:0] VEC_OFF_REFILL  = 32'h0000_0000;
    localparam logic [31:0] VEC_OFF_GENERAL = 32'h0000_0180;
    localparam logic [31:0] VEC_OFF_INT     = 32'h0000_0200;

    // Store-class events must wait for the write path to drain before commit.
    function automatic logic is_store_class(input logic [EXC_CODE_W-1:0] code);
        return (code == EX_AdES) || (code == EX_WrTLBRefillinMEM) ||
               (code == EX_WrTLBInvalidinMEM) || (code == EX_Mod);
    endfunction

endpackage

// File: rtl/int_sync_prio.sv
// Hardware interrupt synchroniser plus IP&IM masking and highest-index encoder.
module int_sync_prio #(
    parameter int unsigned NUM_HW_INT  = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_HW_INT-1:0]   hw_int,
    input  logic [1:0]              ip_sw,
    input  logic [NUM_HW_INT+1:0]   im,
    output logic [NUM_HW_INT-1:0]   ip_hw,
    output logic                    pending_c,
    output logic [2:0]              irq_idx_c
);

    localparam int unsigned IPW = 2 + NUM_HW_INT;

    logic [SYNC_STAGES-1:0][NUM_HW_INT-1:0] sync_q;
    logic [SYNC_STAGES-1:0][NUM_HW_INT-1:0] sync_d;
    logic [IPW-1:0]                         masked;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = hw_int;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign ip_hw     = sync_q[SYNC_STAGES-1];
    assign masked    = {ip_hw, ip_sw} & im;
    assign pending_c = |masked;

    // Ascending scan so the highest set line wins.
    always_comb begin
        irq_idx_c = '0;
        for (int i = 0; i < int'(IPW); i++) begin
            if (masked[i]) begin
                irq_idx_c = 3'(i);
            end
        end
    end

endmodule

// File: rtl/exc_commit_unit.sv
// MEM1 exception arbiter with vector generation and a drain/commit/redirect FSM.
module exc_commit_unit
    import cpu_exc_pkg::*;
#(
    parameter int unsigned NUM_HW_INT       = 6,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter bit          VECTORED_EN      = 1'b1,
    parameter logic [31:0] RESET_VECTOR_BEV = 32'hBFC0_0200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic                     mem_stall,
    input  logic [31:0]              mem_pc,
    input  logic [EXC_FLAGS_W-1:0]   mem_except,
    input  logic [TLB_EXC_W-1:0]     mem_tlb_exc,
    input  logic [NUM_HW_INT-1:0]    hw_int,
    input  logic                     cp0_status_bev,
    input  logic                     cp0_status_exl,
    input  logic                     cp0_status_ie,
    input  logic [NUM_HW_INT+1:0]    cp0_status_im,
    input  logic [1:0]               cp0_cause_ip_sw,
    input  logic                     cp0_cause_iv,
    input  logic [4:0]               cp0_intctl_vs,
    input  logic [31:0]              cp0_ebase,
    input  logic                     sb_empty,
    input  logic                     redirect_ack,
    output logic [EXC_CODE_W-1:0]    exc_code,
    output logic [ENTRY_SEL_W-1:0]   entry_sel,
    output logic [31:0]              exc_vector,
    output logic                     flush_req,
    output logic                     redirect_valid,
    output logic                     cp0_commit,
    output logic [NUM_HW_INT-1:0]    cp0_ip_hw,
    output logic                     busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_COMMIT   = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

    ExceptinPipeType          flags;
    logic                     pending_c;
    logic [2:0]               irq_idx_c;
    logic                     int_req;
    logic                     ev_take;
    logic [EXC_CODE_W-1:0]    ev_code;
    logic [ENTRY_SEL_W-1:0]   ev_sel;
    logic                     ev_refill;
    logic [31:0]              ev_base;
    logic [31:0]              ev_offset;
    logic [31:0]              ev_vector;

    logic [1:0]               state_q,          state_d;
    logic [EXC_CODE_W-1:0]    exc_code_q,       exc_code_d;
    logic [ENTRY_SEL_W-1:0]   entry_sel_q,      entry_sel_d;
    logic [31:0]              exc_vector_q,     exc_vector_d;
    logic                     flush_req_q,      flush_req_d;
    logic                     redirect_valid_q, redirect_valid_d;
    logic                     cp0_commit_q,     cp0_commit_d;
    logic                     busy_q,           busy_d;

    int_sync_prio #(
        .NUM_HW_INT  (NUM_HW_INT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_int_sync_prio (
        .clk       (clk),
        .rst       (rst),
        .hw_int    (hw_int),
        .ip_sw     (cp0_cause_ip_sw),
        .im        (cp0_status_im),
        .ip_hw     (cp0_ip_hw),
        .pending_c (pending_c),
        .irq_idx_c (irq_idx_c)
    );

    assign flags   = mem_except;
    assign int_req = mem_valid & (mem_pc != 32'd0) & pending_c &
                     cp0_status_ie & ~cp0_status_exl;

    // Priority encoder over all exception sources, highest first.
    always_comb begin
        ev_code   = EX_None;
        ev_sel    = IsException;
        ev_refill = 1'b0;
        if (flags.refetch) begin
            ev_code = EX_Refetch;
            ev_sel  = IsRefetch;
        end else if (int_req) begin
            ev_code = EX_Interrupt;
        end else if (mem_pc[1:0] != 2'b00) begin
            ev_code = EX_AdELIF;
        end else if (flags.tlb_refill_if) begin
            ev_code   = EX_TLBRefillIF;
            ev_refill = 1'b1;
        end else if (flags.tlb_invalid_if) begin
            ev_code = EX_TLBInvalidIF;
        end else if (flags.cpu) begin
            ev_code = EX_CpU;
        end else if (flags.ri) begin
            ev_code = EX_RI;
        end else if (flags.syscall) begin
            ev_code = EX_Syscall;
        end else if (flags.brk) begin
            ev_code = EX_Break;
        end else if (flags.eret) begin
            ev_code = EX_Eret;
            ev_sel  = IsEret;
        end else if (flags.trap) begin
            ev_code = EX_Trap;
        end else if (flags.ov) begin
            ev_code = EX_Ov;
        end else if (flags.ades) begin
            ev_code = EX_AdES;
        end else if (flags.adel) begin
            ev_code = EX_AdEL;
        end else begin
            case (mem_tlb_exc)
                MEM_RdTLBRefill: begin
                    ev_code   = EX_RdTLBRefillinMEM;
                    ev_refill = 1'b1;
                end
                MEM_WrTLBRefill: begin
                    ev_code   = EX_WrTLBRefillinMEM;
                    ev_refill = 1'b1;
                end
                MEM_RdTLBInvalid: ev_code = EX_RdTLBInvalidinMEM;
                MEM_WrTLBInvalid: ev_code = EX_WrTLBInvalidinMEM;
                MEM_TLBModified:  ev_code = EX_Mod;
                default:          ev_code = EX_None;
            endcase
        end
        if (ev_code == EX_None) begin
            ev_sel = IsNone;
        end
    end

    // Entry vector: BEV-selected base plus refill/general/interrupt offset.
    always_comb begin
        ev_base = cp0_status_bev ? RESET_VECTOR_BEV : cp0_ebase;
        if (ev_refill && !cp0_status_exl) begin
            ev_offset = VEC_OFF_REFILL;
        end else if ((ev_code == EX_Interrupt) && cp0_cause_iv) begin
            ev_offset = VEC_OFF_INT;
            if (VECTORED_EN && !cp0_status_bev && (cp0_intctl_vs != 5'd0)) begin
                ev_offset = VEC_OFF_INT + 32'(irq_idx_c) * (32'(cp0_intctl_vs) << 5);
            end
        end else begin
            ev_offset = VEC_OFF_GENERAL;
        end
        ev_vector = ev_base + ev_offset;
    end

    assign ev_take = mem_valid & ~mem_stall & (ev_code != EX_None);

    // Commit FSM; outputs are registered from the next state.
    always_comb begin
        state_d      = state_q;
        exc_code_d   = exc_code_q;
        entry_sel_d  = entry_sel_q;
        exc_vector_d = exc_vector_q;
        case (state_q)
            ST_IDLE: begin
                if (ev_take) begin
                    exc_code_d   = ev_code;
                    entry_sel_d  = ev_sel;
                    exc_vector_d = ev_vector;
                    state_d      = (is_store_class(ev_code) || !sb_empty) ? ST_DRAIN : ST_COMMIT;
                end
            end
            ST_DRAIN: begin
                if (sb_empty) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (redirect_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        flush_req_d      = (state_d != ST_IDLE);
        busy_d           = (state_d != ST_IDLE);
        redirect_valid_d = (state_d == ST_REDIRECT);
        cp0_commit_d     = (state_d == ST_COMMIT) && (entry_sel_d == IsException);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            exc_code_q       <= EX_None;
            entry_sel_q      <= IsNone;
            exc_vector_q     <= 32'd0;
            flush_req_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            cp0_commit_q     <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            exc_code_q       <= exc_code_d;
            entry_sel_q      <= entry_sel_d;
            exc_vector_q     <= exc_vector_d;
            flush_req_q      <= flush_req_d;
            redirect_valid_q <= redirect_valid_d;
            cp0_commit_q     <= cp0_commit_d;
            busy_q           <= busy_d;
        end
    end

    assign exc_code       = exc_code_q;
    assign entry_sel      = entry_sel_q;
    assign exc_vector     = exc_vector_q;
    assign flush_req      = flush_req_q;
    assign redirect_valid = redirect_valid_q;
    assign cp0_commit     = cp0_commit_q;
    assign busy           = busy_q;

endmodule

// File: doc/exc_commit_unit.md
Name: exc_commit_unit

Overview:
- Parametrised, sequential successor of the MEM1 exception arbiter.
- Samples and synchronises hardware interrupt lines, prioritises the MEM-stage exception, and computes the entry vector, including MIPS32r2 vectored-interrupt offsets.
- Runs a commit FSM that drains the store path, issues one CP0 commit strobe, and holds the flush/redirect until IF acknowledges it.
- Sits between MEM1 and CP0/IF/NPC.

Parameters:
- NUM_HW_INT, 6, number of hardware interrupt lines (1..6). The IP vector is 2+NUM_HW_INT bits.
- SYNC_STAGES, 2, synchroniser depth for hw_int (≥1).
- VECTORED_EN, 1, enables the Cause.IV/IntCtl.VS vectored offset logic.
- RESET_VECTOR_BEV, 32'hBFC00200, exception base used when Status.BEV=1.

Ports:
- clk, in, 1, core clock.
- rst, in, 1, synchronous active-low reset.
- mem_valid, in, 1, MEM-stage instruction valid.
- mem_stall, in, 1, MEM stage held this cycle.
- mem_pc, in, 32, MEM-stage PC.
- mem_except, in, EXC_FLAGS_W, decoded exception flags (ExceptinPipeType layout).
- mem_tlb_exc, in, 3, MEM TLB exception code.
- hw_int, in, NUM_HW_INT, raw asynchronous interrupt lines.
- cp0_status_bev, in, 1, Status.BEV.
- cp0_status_exl, in, 1, Status.EXL.
- cp0_status_ie, in, 1, Status.IE.
- cp0_status_im, in, 2+NUM_HW_INT, Status.IM.
- cp0_cause_ip_sw, in, 2, Cause.IP1..0.
- cp0_cause_iv, in, 1, Cause.IV.
- cp0_intctl_vs, in, 5, IntCtl.VS.
- cp0_ebase, in, 32, EBase.
- sb_empty, in, 1, store buffer / uncached write path drained.
- redirect_ack, in, 1, IF accepted the redirect.
- exc_code, out, 5, latched EX_* code of the committed event.
- entry_sel, out, 3, IsNone/IsException/IsEret/IsRefetch.
- exc_vector, out, 32, latched entry address.
- flush_req, out, 1, flushes IF..MEM.
- redirect_valid, out, 1, NPC redirect valid.
- cp0_commit, out, 1, one-cycle strobe: CP0 writes EPC/Cause/EXL.
- cp0_ip_hw, out, NUM_HW_INT, synchronised hw lines for Cause.IP7..2.
- busy, out, 1, FSM not IDLE.

Behaviour:
- Reset (rst=0 at a clk edge): FSM=IDLE; synchroniser flops=0; exc_code=EX_None; entry_sel=IsNone; exc_vector=0; flush_req=0; redirect_valid=0; cp0_commit=0; busy=0. Reset overrides every state, including mid-DRAIN and mid-REDIRECT.
- Synchroniser: hw_int passes through SYNC_STAGES flops; cp0_ip_hw is the last stage. IP = {cp0_ip_hw, cp0_cause_ip_sw}.
- int_req = mem_valid & (mem_pc!=0) & |(IP & IM) & IE & ~EXL.
- Exception priority, highest first: Refetch, Interrupt, AdEL-IF (mem_pc[1:0]!=0), TLBRefill-IF, TLBInvalid-IF, CpU, RI, Syscall, Break, Eret, Trap, Ov, AdES, AdEL, RdTLBRefill, WrTLBRefill, RdTLBInvalid, WrTLBInvalid, Mod.
- Event: mem_valid & ~mem_stall & (any flag | int_req).
- Vector: base = BEV ? RESET_VECTOR_BEV : cp0_ebase.
  - TLB refill with EXL=0: offset 0x000.
  - Interrupt with IV=1: offset 0x200; if additionally VECTORED_EN=1, BEV=0 and VS!=0: offset 0x200 + n*(VS<<5), where n = highest set index of IP&IM (IP7 highest).
  - All other exceptions: offset 0x180.
  - Sum is 32-bit, wrap ignored.
- FSM states:
  - IDLE: on an event, latch exc_code, entry_sel and exc_vector, and assert flush_req in the next cycle. If the code is a store-class exception (AdES, WrTLB*, Mod) or sb_empty=0, go to DRAIN; else go to COMMIT.
  - DRAIN: flush_req=1; wait for sb_empty=1, then go to COMMIT.
  - COMMIT: one cycle; cp0_commit=1 only if entry_sel=IsException (Eret and Refetch do not pulse it); flush_req=1; go to REDIRECT.
  - REDIRECT: flush_req=1, redirect_valid=1; exc_vector stays stable. On redirect_ack, go to IDLE and drop both outputs in the same edge.
- Minimum latency from event to redirect_valid: 2 cycles.
- While busy=1, new MEM events are ignored; MEM is already flushed.
- An interrupt rising during DRAIN/COMMIT/REDIRECT is not re-latched; it is taken after IDLE if still pending.
- An event together with mem_stall=1 is not taken.
- redirect_ack outside REDIRECT is ignored.
- flush_req is asserted continuously from the cycle after the event until ack.

Decomposition:
- Shared package (cpu_exc_pkg): ExceptinPipeType, EX_* codes, Is* entry selects, MEM_* TLB codes, EXC_FLAGS_W, vector offset constants (0x000/0x180/0x200).
- Sub-module int_sync_prio: synchroniser, IP&IM masking and highest-index encoder. Outputs cp0_ip_hw, the pending flag and the index n.

Test Plan:
- Syscall: mem_pc=0x80001000, BEV=0, EBase=0x80000000, sb_empty=1 → flush_req at T+1; cp0_commit pulse at T+1; redirect_valid at T+2 with exc_vector=0x80000180, exc_code=EX_Syscall; held until ack.
- Vectored interrupt: hw_int[3] (IP5) and IM5=1, IE=1, EXL=0, IV=1, VS=1, EBase=0x80000000 → seen after 2 sync cycles; exc_vector=0x80000200+5*0x20=0x800002A0.
- TLB store refill: EXL=0, sb_empty=0 for 4 cycles → stays in DRAIN 4 cycles with flush_req=1 and no cp0_commit; then commit; vector=EBase+0x000, code EX_WrTLBRefillinMEM.
- Eret + Refetch priority: both flags set → entry_sel=IsRefetch, no cp0_commit. Eret alone → IsEret, no commit.
- Reset mid-REDIRECT: rst=0 for one cycle → all outputs 0, busy=0 next cycle; a later Break event is processed normally.
- BEV=1 with AdEL-IF (mem_pc=0x80000002) → exc_vector=0xBFC00380; a redirect_ack delayed 10 cycles keeps outputs stable.
